// File: rtl/paral_serial_lanes_if.sv
// Lane bus between the byte-striping logic and the serialiser: per-lane symbols
// and valids in, load strobe, serial bits and data-mode flag out.
interface paral_serial_lanes_if #(
  parameter int unsigned LANES = 2,
  parameter int unsigned WIDTH = 8
);
  logic [LANES*WIDTH-1:0] data_in;
  logic [LANES-1:0]       valid_in;
  logic                   load;
  logic [LANES-1:0]       serial_out;
  logic                   active;

  modport master (output data_in, valid_in, input load, serial_out, active);
  modport slave  (input data_in, valid_in, output load, serial_out, active);
endinterface

// File: rtl/paral_serial_lanes.sv
// N-lane MSB-first parallel-to-serial transmitter: COM training burst after
// reset, then per-lane data or IDLE symbols back to back.
module paral_serial_lanes #(
  parameter int unsigned     LANES     = 2,
  parameter int unsigned     WIDTH     = 8,
  parameter logic [WIDTH-1:0] COM_SYM  = 8'hBC,
  parameter logic [WIDTH-1:0] IDLE_SYM = 8'h7C,
  parameter int unsigned     COM_COUNT = 4
) (
  input  logic                clk_8f,
  input  logic                reset,
  paral_serial_lanes_if.slave lanes
);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned NW = $clog2(COM_COUNT + 1);

  typedef enum logic {TRAIN, ACTIVE} state_t;

  state_t                        state, state_nxt;
  logic [CW-1:0]                 cnt;
  logic [NW-1:0]                 com_cnt;
  logic [LANES-1:0][WIDTH-1:0]   shreg, sym_nxt;
  logic                          load_i;
  logic                          data_mode;

  assign load_i = (cnt == CW'(WIDTH - 1));
  // The load edge that sees the full COM count already carries data.
  assign data_mode = (state == ACTIVE) || (com_cnt == NW'(COM_COUNT));

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) state <= TRAIN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == TRAIN && load_i && com_cnt == NW'(COM_COUNT))
      state_nxt = ACTIVE;
  end

  always_comb begin
    lanes.load   = load_i;
    lanes.active = (state == ACTIVE);
    for (int unsigned i = 0; i < LANES; i++)
      lanes.serial_out[i] = shreg[i][WIDTH-1];
  end

  always_comb begin
    sym_nxt = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (!data_mode)             sym_nxt[i] = COM_SYM;
      else if (lanes.valid_in[i]) sym_nxt[i] = lanes.data_in[i*WIDTH +: WIDTH];
      else                        sym_nxt[i] = IDLE_SYM;
    end
  end

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      cnt     <= CW'(WIDTH - 1);
      com_cnt <= '0;
      shreg   <= '0;
    end else begin
      cnt <= load_i ? '0 : cnt + 1'b1;
      if (load_i && state == TRAIN && com_cnt != NW'(COM_COUNT))
        com_cnt <= com_cnt + 1'b1;
      for (int unsigned i = 0; i < LANES; i++)
        shreg[i] <= load_i ? sym_nxt[i] : {shreg[i][WIDTH-2:0], 1'b0};
    end
  end
endmodule

// File: tb/tb_paral_serial_lanes.sv
// Bench for paral_serial_lanes: two configurations checked every cycle against
// a symbol-index model, plus literal bit-pattern checks.
module tb_paral_serial_lanes;
  logic clk_8f = 1'b0;
  logic rst_a  = 1'b0;
  logic rst_b  = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_8f = ~clk_8f;

  paral_serial_lanes_if #(.LANES(2), .WIDTH(8))  ifa ();
  paral_serial_lanes_if #(.LANES(4), .WIDTH(10)) ifb ();

  paral_serial_lanes #(
    .LANES(2), .WIDTH(8), .COM_SYM(8'hBC), .IDLE_SYM(8'h7C), .COM_COUNT(4)
  ) dut_a (.clk_8f(clk_8f), .reset(rst_a), .lanes(ifa));

  paral_serial_lanes #(
    .LANES(4), .WIDTH(10), .COM_SYM(10'h17C), .IDLE_SYM(10'h283), .COM_COUNT(2)
  ) dut_b (.clk_8f(clk_8f), .reset(rst_b), .lanes(ifb));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: edges since reset release; symbol k starts at edge k*W.
  int ea = -1, eb = -1;
  logic [7:0] syma [2];
  logic [9:0] symb [4];

  always @(posedge clk_8f or negedge rst_a) begin
    if (!rst_a) ea = -1;
    else begin
      ea++;
      if (ea % 8 == 0)
        for (int i = 0; i < 2; i++)
          syma[i] = (ea / 8 < 4) ? 8'hBC : (ifa.valid_in[i] ? ifa.data_in[i*8 +: 8] : 8'h7C);
    end
  end

  always @(posedge clk_8f or negedge rst_b) begin
    if (!rst_b) eb = -1;
    else begin
      eb++;
      if (eb % 10 == 0)
        for (int i = 0; i < 4; i++)
          symb[i] = (eb / 10 < 2) ? 10'h17C : (ifb.valid_in[i] ? ifb.data_in[i*10 +: 10] : 10'h283);
    end
  end

  always @(negedge clk_8f) begin
    logic [1:0] sa;
    logic [3:0] sb;
    if (ea < 0) chk("a_reset", {ifa.serial_out, ifa.load, ifa.active}, {2'b00, 1'b1, 1'b0});
    else begin
      for (int i = 0; i < 2; i++) sa[i] = syma[i][7 - ea % 8];
      chk("a_serial", ifa.serial_out, sa);
      chk("a_load", ifa.load, ea % 8 == 7);
      chk("a_active", ifa.active, ea / 8 >= 4);
    end
    if (eb < 0) chk("b_reset", {ifb.serial_out, ifb.load, ifb.active}, {4'b0000, 1'b1, 1'b0});
    else begin
      for (int i = 0; i < 4; i++) sb[i] = symb[i][9 - eb % 10];
      chk("b_serial", ifb.serial_out, sb);
      chk("b_load", ifb.load, eb % 10 == 9);
      chk("b_active", ifb.active, eb / 10 >= 2);
    end
  end

  task automatic wait_load_a();
    int n = 0;
    while (ifa.load !== 1'b1 && n < 20) begin @(negedge clk_8f); n++; end
    chk("a_load_wait", ifa.load, 1'b1);
  endtask

  task automatic wait_load_b();
    int n = 0;
    while (ifb.load !== 1'b1 && n < 20) begin @(negedge clk_8f); n++; end
    chk("b_load_wait", ifb.load, 1'b1);
  endtask

  // Called at a negedge with load high; returns at the next such negedge.
  task automatic send_a(input logic [1:0] v, input logic [15:0] d, input bit chg,
                        input logic [15:0] d2, output logic [1:0][7:0] cap);
    ifa.valid_in = v;
    ifa.data_in  = d;
    for (int b = 0; b < 8; b++) begin
      @(negedge clk_8f);
      cap[0][7-b] = ifa.serial_out[0];
      cap[1][7-b] = ifa.serial_out[1];
      if (chg && b == 2) ifa.data_in = d2;
    end
  endtask

  task automatic send_b(input logic [3:0] v, input logic [39:0] d,
                        output logic [3:0][9:0] cap);
    ifb.valid_in = v;
    ifb.data_in  = d;
    for (int b = 0; b < 10; b++) begin
      @(negedge clk_8f);
      for (int i = 0; i < 4; i++) cap[i][9-b] = ifb.serial_out[i];
    end
  endtask

  initial begin
    logic [1:0][7:0] ca;
    logic [3:0][9:0] cb;
    logic [47:0]     s0, s1;
    ifa.valid_in = '0; ifa.data_in = '0;
    ifb.valid_in = '0; ifb.data_in = '0;
    repeat (3) @(negedge clk_8f);
    chk("a_reset_load", ifa.load, 1'b1);
    chk("a_reset_active", ifa.active, 1'b0);
    rst_a = 1'b1;
    wait_load_a();

    for (int k = 0; k < 4; k++) begin
      send_a(2'b00, 16'h0000, 1'b0, 16'h0, ca);
      chk("a_com0", ca[0], 8'hBC);
      chk("a_com1", ca[1], 8'hBC);
      chk("a_train_active", ifa.active, 1'b0);
    end
    send_a(2'b00, 16'h0000, 1'b0, 16'h0, ca);
    chk("a_idle0", ca[0], 8'h7C);
    chk("a_idle1", ca[1], 8'h7C);
    chk("a_active_up", ifa.active, 1'b1);

    send_a(2'b01, 16'h32A4, 1'b0, 16'h0, ca);
    chk("a_mix0", ca[0], 8'hA4);
    chk("a_mix1", ca[1], 8'h7C);

    s0 = '0; s1 = '0;
    send_a(2'b11, 16'h00FF, 1'b0, 16'h0, ca); s0[23:16] = ca[0]; s1[23:16] = ca[1];
    send_a(2'b11, 16'h01EE, 1'b0, 16'h0, ca); s0[15:8]  = ca[0]; s1[15:8]  = ca[1];
    send_a(2'b11, 16'h02DD, 1'b0, 16'h0, ca); s0[7:0]   = ca[0]; s1[7:0]   = ca[1];
    chk("a_stream0", s0[23:0], 24'hFFEEDD);
    chk("a_stream1", s1[23:0], 24'h000102);

    send_a(2'b11, 16'hCCCC, 1'b1, 16'h3333, ca);
    chk("a_midchg0", ca[0], 8'hCC);
    chk("a_midchg1", ca[1], 8'hCC);
    send_a(2'b11, 16'h3333, 1'b0, 16'h0, ca);
    chk("a_after0", ca[0], 8'h33);

    ifa.valid_in = 2'b11; ifa.data_in = 16'hFFFF;
    repeat (3) @(negedge clk_8f);
    #2 rst_a = 1'b0;
    #1;
    chk("a_abort_serial", ifa.serial_out, 2'b00);
    chk("a_abort_active", ifa.active, 1'b0);
    chk("a_abort_load", ifa.load, 1'b1);
    repeat (2) @(negedge clk_8f);
    rst_a = 1'b1;
    wait_load_a();
    for (int k = 0; k < 4; k++) begin
      send_a(2'b11, 16'h5A5A, 1'b0, 16'h0, ca);
      chk("a_recom0", ca[0], 8'hBC);
      chk("a_recom1", ca[1], 8'hBC);
    end
    for (int k = 0; k < 40; k++)
      send_a(2'($urandom), 16'($urandom), 1'($urandom), 16'($urandom), ca);

    rst_b = 1'b1;
    wait_load_b();
    for (int k = 0; k < 2; k++) begin
      send_b(4'hF, 40'hFF_FFFF_FFFF, cb);
      for (int i = 0; i < 4; i++) chk("b_com", cb[i], 10'h17C);
    end
    send_b(4'b0100, {10'h0, 10'h3A5, 10'h0, 10'h0}, cb);
    chk("b_lane2", cb[2], 10'h3A5);
    chk("b_lane0", cb[0], 10'h283);
    chk("b_lane3", cb[3], 10'h283);
    chk("b_active", ifb.active, 1'b1);
    for (int k = 0; k < 20; k++)
      send_b(4'($urandom), {8'($urandom), $urandom}, cb);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/paral_serial_lanes.md
Name: paral_serial_lanes

Overview:
Parametrised N-lane parallel-to-serial transmitter. It is the next generation of the two-lane 8-bit phy_tx serialiser and runs on the single serial clock clk_8f.
- Each lane shifts out one WIDTH-bit symbol, MSB first, every WIDTH cycles.
- After reset it sends a COM training sequence on all lanes, then switches to data mode.
- In data mode, an invalid lane slot sends the IDLE symbol.
- Sits between the upstream byte-striping logic and the PHY serial lines.

Parameters:
LANES, 2, number of independent serial lanes (>=1)
WIDTH, 8, symbol width in bits (>=2)
COM_SYM, 8'hBC, training/comma symbol, WIDTH bits
IDLE_SYM, 8'h7C, symbol sent when a lane's valid_in is low in data mode, WIDTH bits
COM_COUNT, 4, number of COM symbols sent after reset before entering data mode (>=1)

Ports:
clk_8f  input  1  serial bit clock; only clock in the block
reset  input  1  asynchronous, active-low reset
data_in  input  LANES*WIDTH  lane i symbol on bits [i*WIDTH +: WIDTH]
valid_in  input  LANES  per-lane valid for the data_in slot
load  output  1  high in the cycle in which data_in/valid_in are sampled at the next rising edge
serial_out  output  LANES  serial bit per lane
active  output  1  high once the COM sequence is done (data mode)

Behaviour:
- Reset (reset=0, async): bit counter cnt=WIDTH-1, all shift registers=0, com counter=0, state=TRAIN. Output values: serial_out=0, active=0, load=1.
- cnt increments every clk_8f edge and wraps WIDTH-1 -> 0.
- load = (cnt == WIDTH-1), combinational.
- Load edge (rising edge with load=1): each lane's shift register takes its next symbol. Otherwise each shift register shifts left by 1, filling 0.
- serial_out[i] = MSB of lane i's shift register.
- Latency: the symbol sampled at load edge k drives bits MSB..LSB during the cycles following edges k .. k+WIDTH-1. There are no gaps between consecutive symbols.
- State TRAIN:
  - Every load edge loads COM_SYM on all lanes; valid_in and data_in are ignored.
  - The com counter increments on each such load.
  - At the load edge where the com counter already equals COM_COUNT: state becomes ACTIVE, active rises, and that same load takes data/IDLE per ACTIVE rules. Exactly COM_COUNT COM symbols are sent.
- State ACTIVE:
  - Lane i loads data_in[i] if valid_in[i]=1, else IDLE_SYM.
  - Lanes are independent; any mix of valid and invalid lanes is legal.
  - ACTIVE is left only by reset.
- Inputs are sampled only on load edges. Changes while load=0 have no effect.
- Reset asserted mid-symbol: the in-flight symbol is aborted and outputs immediately take their reset values. On release, the full COM sequence restarts, with the first COM loaded on the first edge after release.
- The com counter is sized to hold COM_COUNT and saturates once in ACTIVE (no wrap).

Test Plan:
1. Defaults; release reset with valid_in=0 -> both lanes output 10111100 four times (32 cycles). At the 5th load edge active rises, then 01111100 repeats on both lanes.
2. In ACTIVE, at a load edge: lane0 valid=1 data 8'hA4, lane1 valid=0 data 8'h32 -> lane0 outputs 10100100, lane1 outputs 01111100.
3. Both lanes valid on three consecutive load edges with lane0 FF/EE/DD and lane1 00/01/02 -> 24 contiguous bits per lane: 11111111 11101110 11011101 and 00000000 00000001 00000010.
4. Change data_in from 8'hCC to 8'h33 while load=0 in the middle of a symbol -> serial stream unchanged; the next symbol uses whatever value is present at the next load edge.
5. Drop reset mid-symbol in ACTIVE -> serial_out=0, active=0, load=1 immediately with no clock edge. After release, the 4x COM sequence repeats before any data is sent.
6. LANES=4, WIDTH=10, COM_COUNT=2, COM_SYM=10'h17C, IDLE_SYM=10'h283 -> all four lanes send 0101111100 twice. active rises at the 3rd load edge. Lane2 valid with 10'h3A5 outputs 1110100101; the other lanes output 1010000011.
